multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that drives the shared datapath through FETCH, DECODE, EXEC, MEM and WB.
- Replaces single-cycle sequencing so that one memory port, behind a ready handshake, serves both instruction fetch and data access.
- Decodes RV32I major opcodes from IR[6:0].
- Pulses the register load enables (lir/lpc/lmar/lmdr), register-file write and PC source selects.
- Traps on illegal opcodes and on memory timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent waiting for mem_ready in one memory state before trapping; legal range >= 2.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset.
- start  in  1  leave IDLE and begin fetching; ignored in every other state.
- halt  in  1  request stop; sampled only at the retire cycle.
- ir_opcode  in  7  IR[6:0]; valid from DECODE onward.
- branch_cond  in  1  ALU compare result; valid in EXEC.
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  1 = store, 0 = read.
- mem_is_fetch  out  1  address mux select: 1 = PC, 0 = MAR.
- lir, lpc, lmar, lmdr  out  1 each  single-cycle load enables.
- pc_src  out  2  00 = PC+4, 01 = PC+imm, 10 = ALU result with bit0 cleared.
- reg_we  out  1  register file write enable.
- wb_sel  out  2  00 = ALU, 01 = MDR, 10 = PC+4, 11 = imm (LUI).
- busy  out  1  FSM is outside IDLE and TRAP.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout.
- state  out  4  encoded state, for debug.
- instret  out  CNT_W  retired instruction count.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state = IDLE. Every output is 0, including instret and trap_cause; the timeout counter is 0. Asserting reset mid-transaction drops mem_req immediately, without waiting for the clock.
- Output timing: state is registered. The remaining outputs are combinational from state, ir_opcode, branch_cond and mem_ready. Each load enable is high for exactly one cycle.
- IDLE: start=1 -> FETCH.
- FETCH:
  - Drives mem_req=1, mem_is_fetch=1, mem_we=0.
  - On mem_ready=1: lir=1, next state DECODE.
- DECODE (1 cycle): opcode legal only if [1:0]=11 and [6:2] is one of 01100, 00100, 00000, 01000, 11000, 11011, 11001, 01101, 00101.
  - Illegal -> TRAP with cause 01.
  - Legal -> EXEC.
- EXEC (1 cycle), by opcode:
  - Load/store: lmar=1 -> MEM.
  - Branch: lpc=1; pc_src = 01 if branch_cond else 00; retire.
  - JAL: reg_we=1, wb_sel=10, lpc=1, pc_src=01; retire.
  - JALR: reg_we=1, wb_sel=10, lpc=1, pc_src=10; retire.
  - R-type, I-ALU, LUI, AUIPC -> WB.
- MEM:
  - Drives mem_req=1, mem_is_fetch=0; mem_we=1 for stores, 0 for loads.
  - On mem_ready: a load gives lmdr=1 -> WB; a store gives lpc=1, pc_src=00, retire.
- WB (1 cycle): reg_we=1, lpc=1, pc_src=00; retire. wb_sel is 01 for loads, 11 for LUI, 00 otherwise (AUIPC: the ALU computes PC+imm).
- Retire cycle:
  - instret increments by 1 and saturates at all-ones.
  - Next state is IDLE if halt=1, else FETCH.
- Timeout counter:
  - Cleared on every entry to FETCH or MEM.
  - Increments each cycle spent in FETCH or MEM with mem_ready=0.
  - When it reaches MEM_TIMEOUT-1 with mem_ready still 0: next state TRAP with cause 10, mem_req deasserted.
  - mem_ready=1 in that same cycle wins; no trap is taken.
- TRAP: trap=1, busy=0, all enables 0. Exit only through reset; start is ignored.
- Latency with zero-wait memory:
  - R, I-ALU, LUI, AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch, JAL, JALR: 3 cycles.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: instret counts as described, and an additional output cycle_cnt [CNT_W-1:0] counts every cycle with busy=1, saturating at all-ones.
- Not defined: instret is tied to 0, cycle_cnt is absent, and no counter flops are built.

Test Plan:
- Reset then start with zero-wait memory, IR opcode 0110011 (R-type) -> state sequence FETCH, DECODE, EXEC, WB; reg_we=1 with wb_sel=00 in WB; back in FETCH 4 cycles after start; instret=1.
- Load opcode 0000011 with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles; lmdr pulse in the 4th; WB with wb_sel=01; total 8 cycles.
- Branch opcode 1100011 with branch_cond=1, then again with branch_cond=0 -> pc_src=01 then 00 in EXEC; 3 cycles each; reg_we never asserted.
- Opcode 0000001 -> TRAP with trap_cause=01 the cycle after DECODE. A following start has no effect; only rst_n low clears trap.
- MEM_TIMEOUT=16 and mem_ready held low in FETCH -> TRAP with cause 10 after exactly 16 FETCH cycles. Repeat with mem_ready=1 on the 16th cycle -> no trap, DECODE follows.
- halt=1 during the WB of a store-free sequence -> IDLE after retire with busy=0. rst_n pulsed low mid-MEM -> mem_req=0 immediately and state=IDLE.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for an RV32I datapath sharing one memory port.
// Define SEQ_PERF_CNT_EN to build the instret and cycle_cnt counters; without it instret reads 0.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic [6:0]       ir_opcode,
  input  logic             branch_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_is_fetch,
  output logic             lir,
  output logic             lpc,
  output logic             lmar,
  output logic             lmdr,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  localparam int unsigned   TW       = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IALU   = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  localparam logic [1:0] PC_P4   = 2'b00;
  localparam logic [1:0] PC_IMM  = 2'b01;
  localparam logic [1:0] PC_ALU  = 2'b10;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MDR  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;
  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_TRAP   = 4'd6
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q;
  logic [1:0]    cause_q, cause_d;
  logic          retire_c;
  logic          legal_c;
  logic [4:0]    op5;

  assign op5 = ir_opcode[6:2];

  // Legal RV32I major opcode check
  always_comb begin
    legal_c = 1'b0;
    if (ir_opcode[1:0] == 2'b11) begin
      case (op5)
        OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_c = 1'b1;
        default:                           legal_c = 1'b0;
      endcase
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    retire_c     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    lir          = 1'b0;
    lpc          = 1'b0;
    lmar         = 1'b0;
    lmdr         = 1'b0;
    pc_src       = PC_P4;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          lir     = 1'b1;
          state_d = S_DECODE;
        end else if (tcnt_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end
      end
      S_DECODE: begin
        if (legal_c) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end
      end
      S_EXEC: begin
        case (op5)
          OP_LOAD, OP_STORE: begin
            lmar    = 1'b1;
            state_d = S_MEM;
          end
          OP_BRANCH: begin
            lpc      = 1'b1;
            pc_src   = branch_cond ? PC_IMM : PC_P4;
            retire_c = 1'b1;
          end
          OP_JAL: begin
            reg_we   = 1'b1;
            wb_sel   = WB_PC4;
            lpc      = 1'b1;
            pc_src   = PC_IMM;
            retire_c = 1'b1;
          end
          OP_JALR: begin
            reg_we   = 1'b1;
            wb_sel   = WB_PC4;
            lpc      = 1'b1;
            pc_src   = PC_ALU;
            retire_c = 1'b1;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op5 == OP_STORE);
        if (mem_ready) begin
          if (op5 == OP_STORE) begin
            lpc      = 1'b1;
            retire_c = 1'b1;
          end else begin
            lmdr    = 1'b1;
            state_d = S_WB;
          end
        end else if (tcnt_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        lpc      = 1'b1;
        retire_c = 1'b1;
        if (op5 == OP_LOAD)     wb_sel = WB_MDR;
        else if (op5 == OP_LUI) wb_sel = WB_IMM;
        else                    wb_sel = WB_ALU;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    if (retire_c) state_d = halt ? S_IDLE : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Wait counter restarts on every state change, so each FETCH/MEM visit gets a fresh budget
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if (state_d != state_q) begin
      tcnt_q <= '0;
    end else if (!mem_ready && (state_q == S_FETCH || state_q == S_MEM)) begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign state      = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] cycle_q;

  // Saturating retire and busy-cycle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (retire_c && !(&instret_q)) instret_q <= instret_q + CNT_W'(1);
      if (busy && !(&cycle_q))       cycle_q   <= cycle_q + CNT_W'(1);
    end
  end

  assign instret   = instret_q;
  assign cycle_cnt = cycle_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: opcode table, randomized trace model, directed corner cases.
module tb_multicycle_sequencer;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 32;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic             clk = 1'b0;
  logic             rst_n, start, halt, branch_cond, mem_ready;
  logic [6:0]       ir_opcode;
  logic             mem_req, mem_we, mem_is_fetch, lir, lpc, lmar, lmdr, reg_we, busy, trap;
  logic [1:0]       pc_src, wb_sel, trap_cause;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;
`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt;
`endif

  multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .ir_opcode(ir_opcode),
    .branch_cond(branch_cond), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_is_fetch(mem_is_fetch), .lir(lir), .lpc(lpc), .lmar(lmar), .lmdr(lmdr),
    .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel), .busy(busy), .trap(trap),
    .trap_cause(trap_cause), .state(state), .instret(instret)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy, trap, req, we, isf, lir, lpc, lmar, lmdr;
    logic [1:0] pcs;
    logic       rwe;
    logic [1:0] wbs;
  } out_t;

  typedef struct packed {
    logic rdy;
    logic retire;
    out_t o;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    logic       bc;
    int         lat;
    logic       rwe;
    logic [1:0] wbs;
    logic [1:0] pcs;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int unsigned exp_instret = 0;
  int unsigned exp_cycles = 0;
  bit          idle = 1'b1;
  cyc_t        trace[$];
  vec_t        tbl[10];
  logic [6:0]  lops[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_ir();
`ifdef SEQ_PERF_CNT_EN
    return 32'(exp_instret);
`else
    return 32'd0;
`endif
  endfunction

  function automatic out_t obs();
    out_t o;
    o.busy = busy; o.trap = trap; o.req = mem_req; o.we = mem_we; o.isf = mem_is_fetch;
    o.lir = lir; o.lpc = lpc; o.lmar = lmar; o.lmdr = lmdr; o.pcs = pc_src;
    o.rwe = reg_we; o.wbs = wb_sel;
    return o;
  endfunction

  function automatic void push(input logic rdy, input logic ret, input out_t o);
    cyc_t c;
    c.rdy = rdy; c.retire = ret; c.o = o;
    trace.push_back(c);
  endfunction

  function automatic out_t base();
    out_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  // Expected per-cycle outputs of one instruction, fw/mw = memory wait cycles in fetch/data access
  function automatic void build(input logic [6:0] op, input int fw, input int mw, input logic bc);
    out_t o;
    trace.delete();
    for (int i = 0; i < fw; i++) begin
      o = base(); o.req = 1'b1; o.isf = 1'b1; push(1'b0, 1'b0, o);
    end
    o = base(); o.req = 1'b1; o.isf = 1'b1; o.lir = 1'b1; push(1'b1, 1'b0, o);
    o = base(); push(1'b0, 1'b0, o);
    case (op)
      OPC_LD, OPC_ST: begin
        o = base(); o.lmar = 1'b1; push(1'b0, 1'b0, o);
        for (int i = 0; i < mw; i++) begin
          o = base(); o.req = 1'b1; o.we = (op == OPC_ST); push(1'b0, 1'b0, o);
        end
        o = base(); o.req = 1'b1; o.we = (op == OPC_ST);
        if (op == OPC_ST) begin
          o.lpc = 1'b1; push(1'b1, 1'b1, o);
        end else begin
          o.lmdr = 1'b1; push(1'b1, 1'b0, o);
          o = base(); o.rwe = 1'b1; o.lpc = 1'b1; o.wbs = 2'b01; push(1'b0, 1'b1, o);
        end
      end
      OPC_BR: begin
        o = base(); o.lpc = 1'b1; o.pcs = bc ? 2'b01 : 2'b00; push(1'b0, 1'b1, o);
      end
      OPC_JAL, OPC_JALR: begin
        o = base(); o.rwe = 1'b1; o.wbs = 2'b10; o.lpc = 1'b1;
        o.pcs = (op == OPC_JAL) ? 2'b01 : 2'b10;
        push(1'b0, 1'b1, o);
      end
      default: begin
        o = base(); push(1'b0, 1'b0, o);
        o = base(); o.rwe = 1'b1; o.lpc = 1'b1; o.wbs = (op == OPC_LUI) ? 2'b11 : 2'b00;
        push(1'b0, 1'b1, o);
      end
    endcase
  endfunction

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply the built trace; halt and start are randomized wherever they must be ignored
  task automatic run_trace(input logic [6:0] op, input logic bc, input logic h);
    logic [13:0] a, e;
    for (int i = 0; i < trace.size(); i++) begin
      mem_ready   = trace[i].rdy;
      ir_opcode   = op;
      branch_cond = bc;
      halt        = trace[i].retire ? h : 1'($urandom_range(0, 1));
      start       = 1'($urandom_range(0, 1));
      smp();
      a = obs();
      e = trace[i].o;
      chk($sformatf("trace op=%b cyc%0d", op, i), 32'(a), 32'(e));
      tick();
    end
    exp_cycles  += trace.size();
    exp_instret += 1;
    mem_ready = 1'b0; halt = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    smp();
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("instret", 32'(instret), exp_ir());
    tick();
    start = 1'b0;
    idle  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; halt = 1'b0; mem_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_instret = 0; exp_cycles = 0; idle = 1'b1;
  endtask

  initial begin
    logic [6:0] op;
    logic       bc, h, rwe;
    logic [1:0] wbs, pcs;
    int         fw, mw, lat, n;

    tbl[0] = '{OPC_R,     1'b0, 4, 1'b1, 2'd0, 2'd0};
    tbl[1] = '{OPC_I,     1'b0, 4, 1'b1, 2'd0, 2'd0};
    tbl[2] = '{OPC_LUI,   1'b0, 4, 1'b1, 2'd3, 2'd0};
    tbl[3] = '{OPC_AUIPC, 1'b0, 4, 1'b1, 2'd0, 2'd0};
    tbl[4] = '{OPC_LD,    1'b0, 5, 1'b1, 2'd1, 2'd0};
    tbl[5] = '{OPC_ST,    1'b0, 4, 1'b0, 2'd0, 2'd0};
    tbl[6] = '{OPC_BR,    1'b1, 3, 1'b0, 2'd0, 2'd1};
    tbl[7] = '{OPC_BR,    1'b0, 3, 1'b0, 2'd0, 2'd0};
    tbl[8] = '{OPC_JAL,   1'b0, 3, 1'b1, 2'd2, 2'd1};
    tbl[9] = '{OPC_JALR,  1'b0, 3, 1'b1, 2'd2, 2'd2};
    lops = '{OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};

    rst_n = 1'b0; start = 1'b0; halt = 1'b0; branch_cond = 1'b0;
    mem_ready = 1'b0; ir_opcode = 7'd0;
    smp();
    chk("reset_outputs", 32'(obs()), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cause", 32'(trap_cause), 32'd0);
    chk("reset_instret", 32'(instret), 32'd0);
    rst_n = 1'b1;
    tick();

    // Opcode table with zero-wait memory, back to back
    do_start();
    for (int r = 0; r < 10; r++) begin
      lat = 0; rwe = 1'b0; wbs = 2'b00; pcs = 2'b11;
      for (int k = 0; k < 12 && lat == 0; k++) begin
        ir_opcode = tbl[r].op; branch_cond = tbl[r].bc; mem_ready = 1'b1; halt = 1'b0;
        smp();
        if (reg_we) begin rwe = 1'b1; wbs = wb_sel; end
        if (lpc) begin pcs = pc_src; lat = k + 1; end
        tick();
      end
      chk($sformatf("tbl%0d latency", r), 32'(lat), 32'(tbl[r].lat));
      chk($sformatf("tbl%0d reg_we", r), 32'(rwe), 32'(tbl[r].rwe));
      chk($sformatf("tbl%0d wb_sel", r), 32'(wbs), 32'(tbl[r].wbs));
      chk($sformatf("tbl%0d pc_src", r), 32'(pcs), 32'(tbl[r].pcs));
      exp_cycles  += tbl[r].lat;
      exp_instret += 1;
    end
    mem_ready = 1'b0;

    // Randomized instruction stream against the trace model
    for (int i = 0; i < 60; i++) begin
      op = lops[$urandom_range(0, 8)];
      fw = $urandom_range(0, 4);
      mw = $urandom_range(0, 4);
      bc = 1'($urandom_range(0, 1));
      h  = ($urandom_range(0, 4) == 0);
      if (idle) do_start();
      build(op, fw, mw, bc);
      run_trace(op, bc, h);
      idle = h;
    end
    smp();
    chk("instret_after_random", 32'(instret), exp_ir());
`ifdef SEQ_PERF_CNT_EN
    chk("cycle_cnt_after_random", 32'(cycle_cnt), 32'(exp_cycles));
`endif
    tick();

    // Load with three wait cycles in MEM: eight cycles total
    if (idle) do_start();
    build(OPC_LD, 0, 3, 1'b0);
    run_trace(OPC_LD, 1'b0, 1'b0);

    // Halt at retire returns to IDLE
    do_reset();
    do_start();
    build(OPC_R, 0, 0, 1'b0);
    run_trace(OPC_R, 1'b0, 1'b1);
    smp();
    chk("halt_state_idle", 32'(state), 32'd0);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_instret", 32'(instret), exp_ir());
    tick();

    // Illegal opcode traps after DECODE; start ignored, reset clears
    do_reset();
    do_start();
    ir_opcode = 7'b0000001; mem_ready = 1'b1;
    smp();
    chk("ill_fetch_lir", 32'(lir), 32'd1);
    tick();
    mem_ready = 1'b0;
    smp();
    chk("ill_decode_busy_trap", 32'({busy, trap}), 32'b10);
    tick();
    smp();
    chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_cause", 32'(trap_cause), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b1;
    repeat (3) tick();
    smp();
    chk("ill_start_ignored", 32'({trap, busy, mem_req, trap_cause}), 32'b10001);
    start = 1'b0;
    tick();
    do_reset();
    smp();
    chk("ill_reset_clears", 32'({trap, trap_cause, state}), 32'd0);
    tick();

    // Fetch timeout after exactly MEM_TIMEOUT cycles
    do_start();
    ir_opcode = OPC_R; mem_ready = 1'b0; n = 0;
    for (int i = 0; i < 16; i++) begin
      smp();
      if (mem_req && mem_is_fetch && !trap) n++;
      tick();
    end
    smp();
    chk("tmo_fetch_cycles", 32'(n), 32'd16);
    chk("tmo_fetch_trap", 32'(trap), 32'd1);
    chk("tmo_fetch_cause", 32'(trap_cause), 32'd2);
    chk("tmo_fetch_req_dropped", 32'(mem_req), 32'd0);
    tick();

    // Ready on the last allowed cycle wins
    do_reset();
    do_start();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      mem_ready = (i == 15);
      smp();
      if (mem_req && !trap) n++;
      if (i == 15) chk("tmo_edge_lir", 32'(lir), 32'd1);
      tick();
    end
    mem_ready = 1'b0;
    smp();
    chk("tmo_edge_req_cycles", 32'(n), 32'd16);
    chk("tmo_edge_decode", 32'({trap, busy, mem_req}), 32'b010);
    tick();

    // Data-access timeout on a store
    do_reset();
    do_start();
    ir_opcode = OPC_ST; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      smp();
      if (mem_req && mem_we && !mem_is_fetch && !trap) n++;
      tick();
    end
    smp();
    chk("tmo_mem_cycles", 32'(n), 32'd16);
    chk("tmo_mem_trap_cause", 32'({trap, trap_cause}), 32'b110);
    tick();

    // Asynchronous reset in the middle of MEM
    do_reset();
    do_start();
    ir_opcode = OPC_LD; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    smp();
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_req", 32'(mem_req), 32'd0);
    chk("async_reset_state", 32'(state), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    smp();
    chk("after_reset_idle", 32'({busy, trap, state}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
